// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one SPI master.
// Owns slave selects, the start strobe and the abort timer for each transfer.
module spi_txn_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic [WIDTH-1:0]        rx_data,
  output logic [NREQ-1:0]         ss_n,
  output logic                    spi_start,
  output logic [WIDTH-1:0]        spi_tx_data,
  input  logic                    spi_busy,
  input  logic                    spi_done,
  input  logic [WIDTH-1:0]        spi_rx_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RELEASE
  } state_t;

  state_t                      state, state_nx;
  logic [IW-1:0]               ptr, ptr_nx;
  logic [IW-1:0]               owner, owner_nx;
  logic [TW-1:0]               timer, timer_nx;
  logic [TW-1:0]               timer_inc;
  logic [NREQ-1:0]             grant_nx, ack_nx, ss_n_nx;
  logic                        err_nx, start_nx;
  logic [WIDTH-1:0]            rx_nx, tx_nx;
  logic [NREQ-1:0][WIDTH-1:0]  words;
  logic                        found;
  logic [IW-1:0]               win;
  logic [CW-1:0]               cand;

  assign words     = req_data;
  assign timer_inc = timer + 1'b1;

  // Scan from ptr upward, wrapping, and take the first active request.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NREQ))
        cand = cand - CW'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    timer_nx = timer;
    grant_nx = grant;
    ss_n_nx  = ss_n;
    ack_nx   = '0;
    err_nx   = 1'b0;
    start_nx = 1'b0;
    rx_nx    = rx_data;
    tx_nx    = spi_tx_data;
    unique case (state)
      IDLE: begin
        if (found && !spi_busy) begin
          owner_nx = win;
          grant_nx = NREQ'(1) << win;
          ss_n_nx  = ~(NREQ'(1) << win);
          tx_nx    = words[win];
          state_nx = LOAD;
        end
      end
      LOAD: begin
        state_nx = START;
      end
      START: begin
        start_nx = 1'b1;
        timer_nx = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        timer_nx = timer_inc;
        // A done arriving on the abort cycle still wins: normal completion.
        if (spi_done) begin
          rx_nx    = spi_rx_data;
          ack_nx   = NREQ'(1) << owner;
          grant_nx = '0;
          ss_n_nx  = '1;
          state_nx = RELEASE;
        end else if (timer_inc == TW'(TIMEOUT)) begin
          ack_nx   = NREQ'(1) << owner;
          err_nx   = 1'b1;
          grant_nx = '0;
          ss_n_nx  = '1;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (owner == IW'(NREQ - 1))
          ptr_nx = '0;
        else
          ptr_nx = owner + 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        ss_n_nx  = '1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      timer       <= '0;
      grant       <= '0;
      ack         <= '0;
      err         <= 1'b0;
      spi_start   <= 1'b0;
      ss_n        <= '1;
      spi_tx_data <= '0;
      rx_data     <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      owner       <= owner_nx;
      timer       <= timer_nx;
      grant       <= grant_nx;
      ack         <= ack_nx;
      err         <= err_nx;
      spi_start   <= start_nx;
      ss_n        <= ss_n_nx;
      spi_tx_data <= tx_nx;
      rx_data     <= rx_nx;
    end
  end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: SPI word width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 1023: maximum WAIT cycles before abort (16..65535).
REQ-004 clock  in  1  single system clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester transfer request, level, held until ack.
REQ-007 req_data  in  NREQ*WIDTH  tx word; requester i uses bits [i*WIDTH +: WIDTH].
REQ-008 grant  out  NREQ  one-hot owner of current transfer, registered.
REQ-009 ack  out  NREQ  one-cycle completion pulse to owner, registered.
REQ-010 err  out  1  one-cycle pulse, coincident with ack, on timeout abort.
REQ-011 rx_data  out  WIDTH  word received in last transfer, held until next completion.
REQ-012 ss_n  out  NREQ  active-low slave selects, one per requester.
REQ-013 spi_start  out  1  one-cycle start pulse to SPI master.
REQ-014 spi_tx_data  out  WIDTH  word to SPI master, stable from LOAD until RELEASE.
REQ-015 spi_busy  in  1  SPI master busy.
REQ-016 spi_done  in  1  SPI master one-cycle transfer-complete pulse.
REQ-017 spi_rx_data  in  WIDTH  SPI master received word, valid with spi_done.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, START, WAIT, RELEASE; all outputs registered.
REQ-019 IDLE: if |req and spi_busy==0, SHALL pick winner round-robin starting at ptr, set grant/ss_n[winner]=0, latch req_data word into spi_tx_data, go LOAD.
REQ-020 IDLE with spi_busy==1 SHALL not arbitrate; requests wait.
REQ-021 LOAD: one setup cycle, ss_n held; SHALL go START.
REQ-022 START: spi_start=1 for exactly this cycle; SHALL clear timer, go WAIT.
REQ-023 WAIT: on spi_done, rx_data<=spi_rx_data, ack[owner]=1 next cycle, go RELEASE.
REQ-024 WAIT: timer increments per cycle; when timer==TIMEOUT with no spi_done, SHALL pulse ack[owner] and err, leave rx_data unchanged, go RELEASE.
REQ-025 spi_done and timeout in same cycle SHALL count as normal completion (no err).
REQ-026 RELEASE: ss_n all 1, grant 0 for one cycle; ptr<=owner+1 modulo NREQ (wrap NREQ-1 -> 0); SHALL go IDLE.
REQ-027 Latency: req rising in IDLE at edge N -> grant/ss_n at N+1, spi_start at N+3; ack at edge after spi_done sampled.
REQ-028 req is sampled only in IDLE; owner dropping req mid-transfer SHALL not abort; transfer completes and ack is still issued.
REQ-029 spi_done outside WAIT SHALL be ignored.
REQ-030 At most one grant bit and at most one ss_n bit low at any time.
REQ-031 Minimum gap between consecutive transfers is the RELEASE cycle plus IDLE cycle (ss_n high >=1 cycle).

Reset
REQ-032 reset high SHALL immediately force state=IDLE, ptr=0, timer=0, grant=0, ack=0, err=0, spi_start=0, ss_n=all 1, spi_tx_data=0, rx_data=0.
REQ-033 reset mid-transfer SHALL abort without ack; first post-reset arbitration starts at requester 0.

Verification
REQ-034 Single: req=0001, req_data[7:0]=8'hA5, spi_done after 20 cycles with spi_rx_data=8'h3C -> ss_n=1110, spi_tx_data=A5, one spi_start, ack=0001, rx_data=3C.
REQ-035 Round robin: req=1111 held continuously -> grants in order 0001,0010,0100,1000,0001; each gets one ack.
REQ-036 Timeout: TIMEOUT=16, spi_done never -> ack and err pulse 16 cycles after WAIT entry, rx_data unchanged.
REQ-037 Busy hold-off: spi_busy=1 with req=0100 -> no grant until spi_busy=0, then grant=0100 next edge.
REQ-038 Async reset asserted during WAIT (between clock edges) -> ss_n=1111, grant=0 immediately; no ack; next req=1000 with ptr=0 wins.
REQ-039 Stray spi_done in IDLE and req drop mid-WAIT -> no ack for stray; dropped owner still receives ack.
